// File: rtl/smbs_controller.sv
// smbs_controller: serial frame controller for the 16-line serial multi-bus switch.
// It parses a framed stream on ser_in and then drives the port, lane and data
// lines of the switch for each payload bit. The frame is sent MSB first:
//   start(0) | PORT[1:0] | LANE[1:0] | LEN[LEN_W-1:0] | LEN payload bits
// The lane advances by one (mod 4) for each payload bit.
// Ports:
//   clk        - system clock, rising edge
//   rst        - asynchronous active-high reset
//   ser_in     - serial frame input, idles at 1
//   abort      - synchronous frame cancel; overrides every other transition
//   ser_out    - registered payload bit, goes to the switch serIn
//   p_select   - one-hot port select; 0000 when no payload bit is present
//   l_select   - lane select for the current payload bit; holds its value when idle
//   data_valid - ser_out, p_select and l_select carry a payload bit
//   busy       - a frame is in flight (state is not IDLE)
//   done       - one-cycle pulse when a frame completes
module smbs_controller #(
  parameter int unsigned LEN_W = 4
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       ser_in,
  input  logic       abort,
  output logic       ser_out,
  output logic [3:0] p_select,
  output logic [1:0] l_select,
  output logic       data_valid,
  output logic       busy,
  output logic       done
);

  localparam int unsigned CNT_W = (LEN_W > 2) ? $clog2(LEN_W) : 1;

  typedef enum logic [2:0] {
    S_IDLE,
    S_PORT,
    S_LANE,
    S_LEN,
    S_DATA
  } state_t;

  state_t             state_q;
  logic [1:0]         port_q;
  logic [1:0]         lane_q;     // base lane while parsing, then the current lane
  logic [LEN_W-1:0]   count_q;    // LEN shift register, then the remaining payload bits
  logic [CNT_W-1:0]   bit_cnt_q;  // header bit index within the current field
  logic [LEN_W-1:0]   len_d;

  // LEN value with the current ser_in bit shifted in
  assign len_d = LEN_W'({count_q, ser_in});

  assign busy = (state_q != S_IDLE);

  // Frame sequencer with registered switch outputs
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q    <= S_IDLE;
      port_q     <= 2'd0;
      lane_q     <= 2'd0;
      count_q    <= '0;
      bit_cnt_q  <= '0;
      ser_out    <= 1'b0;
      p_select   <= 4'd0;
      l_select   <= 2'd0;
      data_valid <= 1'b0;
      done       <= 1'b0;
    end else begin
      // Without a payload bit, data and port go to zero; l_select keeps its value
      ser_out    <= 1'b0;
      p_select   <= 4'd0;
      data_valid <= 1'b0;
      done       <= 1'b0;
      if (abort) begin
        state_q   <= S_IDLE;
        bit_cnt_q <= '0;
        count_q   <= '0;
      end else begin
        case (state_q)
          S_IDLE: begin
            if (!ser_in) begin
              state_q   <= S_PORT;
              bit_cnt_q <= '0;
            end
          end
          S_PORT: begin
            port_q <= {port_q[0], ser_in};
            if (bit_cnt_q == CNT_W'(1)) begin
              bit_cnt_q <= '0;
              state_q   <= S_LANE;
            end else begin
              bit_cnt_q <= bit_cnt_q + CNT_W'(1);
            end
          end
          S_LANE: begin
            lane_q <= {lane_q[0], ser_in};
            if (bit_cnt_q == CNT_W'(1)) begin
              bit_cnt_q <= '0;
              state_q   <= S_LEN;
            end else begin
              bit_cnt_q <= bit_cnt_q + CNT_W'(1);
            end
          end
          S_LEN: begin
            count_q <= len_d;
            if (bit_cnt_q == CNT_W'(LEN_W - 1)) begin
              bit_cnt_q <= '0;
              // A zero-length frame completes right after its header
              if (len_d == '0) begin
                done    <= 1'b1;
                state_q <= S_IDLE;
              end else begin
                state_q <= S_DATA;
              end
            end else begin
              bit_cnt_q <= bit_cnt_q + CNT_W'(1);
            end
          end
          S_DATA: begin
            ser_out    <= ser_in;
            p_select   <= 4'b0001 << port_q;
            l_select   <= lane_q;
            data_valid <= 1'b1;
            lane_q     <= lane_q + 2'd1;
            count_q    <= count_q - LEN_W'(1);
            // The last payload bit returns to IDLE, so the next start bit can follow at once
            if (count_q == LEN_W'(1)) begin
              done    <= 1'b1;
              state_q <= S_IDLE;
            end
          end
          default: state_q <= S_IDLE;
        endcase
      end
    end
  end

endmodule

// File: tb/tb_smbs_controller.sv
// tb_smbs_controller: directed-vector bench for smbs_controller.
module tb_smbs_controller;

  logic       clk;
  logic       rst;
  logic       ser_in;
  logic       abort;
  logic       ser_out;
  logic [3:0] p_select;
  logic [1:0] l_select;
  logic       data_valid;
  logic       busy;
  logic       done;

  int errors = 0;
  int checks = 0;

  // Monitor state, sampled on the falling edge
  logic [6:0] obs_q[$];   // {p_select, l_select, ser_out} for each valid cycle
  int done_cnt, done_dv_cnt, busy_cnt, bad_idle_cnt;

  smbs_controller #(.LEN_W(4)) dut (
    .clk        (clk),
    .rst        (rst),
    .ser_in     (ser_in),
    .abort      (abort),
    .ser_out    (ser_out),
    .p_select   (p_select),
    .l_select   (l_select),
    .data_valid (data_valid),
    .busy       (busy),
    .done       (done)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always @(negedge clk) begin
    if (!rst) begin
      if (data_valid) obs_q.push_back({p_select, l_select, ser_out});
      if (done) done_cnt++;
      if (done && data_valid) done_dv_cnt++;
      if (busy) busy_cnt++;
      if (!data_valid && (p_select != 4'd0 || ser_out != 1'b0)) bad_idle_cnt++;
    end
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic clear_mon();
    obs_q.delete();
    done_cnt     = 0;
    done_dv_cnt  = 0;
    busy_cnt     = 0;
    bad_idle_cnt = 0;
  endtask

  // Present one bit (and abort) for the next rising edge, return 1 ns after that edge
  task automatic tick(input logic b, input logic a = 1'b0);
    ser_in = b;
    abort  = a;
    @(posedge clk);
    #1;
    abort = 1'b0;
  endtask

  task automatic send_header(input logic [1:0] port, input logic [1:0] lane, input logic [3:0] len);
    tick(1'b0);
    tick(port[1]); tick(port[0]);
    tick(lane[1]); tick(lane[0]);
    for (int i = 3; i >= 0; i--) tick(len[i]);
  endtask

  task automatic send_frame(input logic [1:0] port, input logic [1:0] lane, input logic [3:0] len,
                            input logic [15:0] pay);
    send_header(port, lane, len);
    for (int i = int'(len) - 1; i >= 0; i--) tick(pay[i]);
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) tick(1'b1);
  endtask

  task automatic check_obs(input string tag, input int idx, input logic [6:0] exp);
    if (idx < obs_q.size()) check(tag, 32'(obs_q[idx]), 32'(exp));
    else                    check(tag, 32'hFFFF_FFFF, 32'(exp));
  endtask

  initial begin
    rst    = 1'b1;
    ser_in = 1'b1;
    abort  = 1'b0;
    clear_mon();
    #12;
    check("reset_outputs", 32'({ser_out, p_select, l_select, data_valid, busy, done}), 32'd0);
    rst = 1'b0;
    @(posedge clk);
    #1;
    idle(2);

    // Basic frame: port 2, lane 1, LEN 3, payload 1,0,1
    clear_mon();
    send_frame(2'd2, 2'd1, 4'd3, 16'b101);
    idle(3);
    check("t1_count", obs_q.size(), 3);
    check_obs("t1_bit0", 0, {4'b0100, 2'b01, 1'b1});
    check_obs("t1_bit1", 1, {4'b0100, 2'b10, 1'b0});
    check_obs("t1_bit2", 2, {4'b0100, 2'b11, 1'b1});
    check("t1_done", done_cnt, 1);
    check("t1_done_with_valid", done_dv_cnt, 1);
    check("t1_busy_cycles", busy_cnt, 11);
    check("t1_idle_zero", bad_idle_cnt, 0);
    check("t1_lsel_hold", 32'(l_select), 32'(2'b11));

    // Lane wrap: port 0, lane 3, LEN 4, payload 1,1,0,1
    clear_mon();
    send_frame(2'd0, 2'd3, 4'd4, 16'b1101);
    idle(3);
    check("t2_count", obs_q.size(), 4);
    check_obs("t2_bit0", 0, {4'b0001, 2'b11, 1'b1});
    check_obs("t2_bit1", 1, {4'b0001, 2'b00, 1'b1});
    check_obs("t2_bit2", 2, {4'b0001, 2'b01, 1'b0});
    check_obs("t2_bit3", 3, {4'b0001, 2'b10, 1'b1});
    check("t2_done", done_cnt, 1);
    check("t2_busy_cycles", busy_cnt, 12);

    // Zero length: port 3, lane 0, LEN 0
    clear_mon();
    send_frame(2'd3, 2'd0, 4'd0, 16'd0);
    check("t3_done_now", 32'(done), 32'd1);
    idle(3);
    check("t3_count", obs_q.size(), 0);
    check("t3_done", done_cnt, 1);
    check("t3_busy_cycles", busy_cnt, 8);
    check("t3_idle_zero", bad_idle_cnt, 0);

    // Back-to-back: A (port 1, lane 0, LEN 1) then B (port 3, lane 2, LEN 2) without a gap
    clear_mon();
    send_frame(2'd1, 2'd0, 4'd1, 16'b1);
    send_frame(2'd3, 2'd2, 4'd2, 16'b01);
    idle(3);
    check("t4_count", obs_q.size(), 3);
    check_obs("t4_a0", 0, {4'b0010, 2'b00, 1'b1});
    check_obs("t4_b0", 1, {4'b1000, 2'b10, 1'b0});
    check_obs("t4_b1", 2, {4'b1000, 2'b11, 1'b1});
    check("t4_done", done_cnt, 2);
    check("t4_done_with_valid", done_dv_cnt, 2);
    check("t4_busy_cycles", busy_cnt, 19);

    // Abort on the second payload edge of a LEN 5 frame
    clear_mon();
    send_header(2'd0, 2'd0, 4'd5);
    tick(1'b1);
    check("t5_valid_before", 32'(data_valid), 32'd1);
    tick(1'b1, 1'b1);
    check("t5_valid_after", 32'(data_valid), 32'd0);
    check("t5_busy_after", 32'(busy), 32'd0);
    idle(3);
    check("t5_count", obs_q.size(), 1);
    check_obs("t5_bit0", 0, {4'b0001, 2'b00, 1'b1});
    check("t5_no_done", done_cnt, 0);
    check("t5_busy_cycles", busy_cnt, 10);
    // Abort together with a start bit in IDLE: the start is ignored
    tick(1'b0, 1'b1);
    check("t5_abort_start", 32'(busy), 32'd0);
    idle(1);
    clear_mon();
    send_frame(2'd1, 2'd2, 4'd2, 16'b10);
    idle(3);
    check("t5_next_count", obs_q.size(), 2);
    check_obs("t5_next0", 0, {4'b0010, 2'b10, 1'b1});
    check_obs("t5_next1", 1, {4'b0010, 2'b11, 1'b0});
    check("t5_next_done", done_cnt, 1);

    // Asynchronous reset in the middle of DATA, between clock edges
    send_header(2'd2, 2'd3, 4'd5);
    tick(1'b1);
    tick(1'b1);
    check("t6_valid_pre", 32'(data_valid), 32'd1);
    #3;
    rst = 1'b1;
    #1;
    check("t6_outputs", 32'({ser_out, p_select, l_select, data_valid, busy, done}), 32'd0);
    @(posedge clk);
    #3;
    rst = 1'b0;
    clear_mon();
    @(posedge clk);
    #1;
    idle(10);
    check("t6_count", obs_q.size(), 0);
    check("t6_done", done_cnt, 0);
    check("t6_busy", busy_cnt, 0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
